display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter DEAD_CYCLES, default 4, legal range 1..255: number of clock_in cycles that all digits stay off between two digits.
REQ-002 clock_in  input  1  system clock (50 MHz); all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tick  input  1  single-cycle scan strobe from the frequency divider (~190 Hz); advances to the next digit.
REQ-005 enable  input  1  level; 1 = scan the display, 0 = display off.
REQ-006 digits_in  input  16  four hex nibbles; [3:0] = digit 0 … [15:12] = digit 3.
REQ-007 dots_in  input  4  decimal point per digit; bit n = digit n, 1 = point lit.
REQ-008 anode  output  4  digit select, active-low, registered.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 dp  output  1  decimal point, active-low, registered.
REQ-011 digit_idx  output  2  index of the current or next digit.
REQ-012 frame_done  output  1  one-cycle pulse when digit 3 finishes.

Function
REQ-013 The FSM SHALL have three states.
- IDLE: display off.
- BLANK: dead time, all digits off.
- SHOW: one digit lit.
REQ-014 In IDLE and BLANK: anode=4'b1111, seg=7'h7F, dp=1.
REQ-015 In SHOW: anode has only bit digit_idx at 0.
- seg = hex decode of latched nibble[digit_idx].
- dp = ~latched dot[digit_idx].
REQ-016 Hex decode table, active-low, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-017 Transition IDLE -> BLANK: on an edge with enable=1.
- digit_idx=0.
- digits_in and dots_in latched into the internal frame register.
REQ-018 BLANK: dead counter increments each cycle; after exactly DEAD_CYCLES cycles in BLANK -> SHOW, counter cleared.
REQ-019 tick asserted in BLANK or IDLE SHALL be ignored; it is not stored.
REQ-020 SHOW with tick=1 -> BLANK, digit_idx <= digit_idx+1 mod 4.
REQ-021 If digit_idx was 3 on that transition:
- frame_done=1 for exactly that one cycle.
- digits_in and dots_in latched for the new frame.
REQ-022 The frame register SHALL change only on the transitions in REQ-017 and REQ-021; input changes mid-frame do not affect the displayed digits.
REQ-023 enable=0 on any edge -> IDLE next edge, overriding tick.
- digit_idx=0, dead counter=0.
- frame_done is not pulsed.
REQ-024 Anode/seg/dp SHALL be registered and update on the same edge as the state change; no combinational path from any input to these outputs.
REQ-025 At most one anode bit SHALL be low at any cycle, and never in the cycle adjacent to a different anode bit being low (dead time ≥ DEAD_CYCLES).

Reset
REQ-026 reset=1 SHALL asynchronously force these values:
- state=IDLE, anode=4'b1111, seg=7'h7F, dp=1.
- digit_idx=0, frame_done=0, dead counter=0, frame register=0.
REQ-027 Reset mid-SHOW SHALL blank the display immediately, without waiting for a clock edge.
REQ-028 After reset release with enable=1, IDLE -> BLANK on the first rising edge.

Verification
REQ-029 Start-up, DEAD_CYCLES=4, digits_in=16'h1234, dots_in=0, enable=1 after reset:
- anode=4'b1110 and seg=7'h19 (digit 4) exactly 5 edges later.
- dp=1 in that same cycle.
REQ-030 Full frame, ticks every 100 cycles:
- digits shown in order: 0 (seg 19), 1 (seg 30), 2 (seg 24), 3 (seg 79).
- 4 blank cycles between each digit.
- frame_done pulses once, 1 cycle, on leaving digit 3.
REQ-031 digits_in changed to 16'hFFFF while digit 1 is shown:
- digits 2 and 3 still show the old values.
- next frame shows seg=7'h0E on all digits.
REQ-032 tick asserted during BLANK: ignored; the digit still advances only once per tick accepted in SHOW.
REQ-033 enable dropped in SHOW on digit 2:
- anode=4'b1111 next edge, frame_done=0.
- re-enable restarts at digit 0.
REQ-034 Asynchronous reset pulse mid-SHOW between clock edges:
- anode=4'b1111 and seg=7'h7F before the next edge.
- dots_in=4'b0001 after restart gives dp=0 on digit 0 only.

Source files
------------

// File: rtl/display_scanner_if.sv
// display_scanner_if: scan control inputs and registered display-drive outputs
interface display_scanner_if;
  logic        tick;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dots_in;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_done;
  modport master (output tick, enable, digits_in, dots_in,
                  input  anode, seg, dp, digit_idx, frame_done);
  modport slave  (input  tick, enable, digits_in, dots_in,
                  output anode, seg, dp, digit_idx, frame_done);
endinterface

// File: rtl/display_scanner.sv
// display_scanner: 4-digit multiplexed 7-segment driver with dead time between digits
module display_scanner #(
  parameter int DEAD_CYCLES = 4
) (
  input logic             clock_in,
  input logic             reset,
  display_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] frame, frame_nxt;
  logic [3:0]  dots, dots_nxt;
  logic        done_nxt;
  logic [3:0]  anode_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    frame_nxt = frame;
    dots_nxt  = dots;
    done_nxt  = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          frame_nxt = bus.digits_in;
          dots_nxt  = bus.dots_in;
        end
        BLANK: begin
          state_nxt = (cnt == 8'(DEAD_CYCLES - 1)) ? SHOW : BLANK;
          cnt_nxt   = (cnt == 8'(DEAD_CYCLES - 1)) ? 8'd0 : cnt + 8'd1;
        end
        SHOW: if (bus.tick) begin
          state_nxt = BLANK;
          idx_nxt   = idx + 2'd1;
          done_nxt  = (idx == 2'd3);
          frame_nxt = (idx == 2'd3) ? bus.digits_in : frame;
          dots_nxt  = (idx == 2'd3) ? bus.dots_in : dots;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // SHOW is only entered from BLANK or held, so idx/frame are already final here
    anode_nxt = (state_nxt == SHOW) ? ~(4'b0001 << idx) : 4'b1111;
    seg_nxt   = (state_nxt == SHOW) ? hex7(frame[{idx, 2'b00} +: 4]) : 7'h7F;
    dp_nxt    = (state_nxt == SHOW) ? ~dots[idx] : 1'b1;
  end
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      frame          <= '0;
      dots           <= '0;
      bus.anode      <= 4'b1111;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      frame          <= frame_nxt;
      dots           <= dots_nxt;
      bus.anode      <= anode_nxt;
      bus.seg        <= seg_nxt;
      bus.dp         <= dp_nxt;
      bus.frame_done <= done_nxt;
    end
  end
  assign bus.digit_idx = idx;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed scenario checks of the display scanner
module tb_display_scanner;
  logic clock_in;
  logic reset;
  int   checks;
  int   errors;
  display_scanner_if bus();
  display_scanner #(.DEAD_CYCLES(4)) dut (.clock_in(clock_in), .reset(reset), .bus(bus));
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end
  // Starts with digit d lit; dwells, ticks, checks the 4-cycle dead time and lands on the next digit lit.
  task automatic run_digit(input logic [1:0] d, input logic [6:0] seg_e, input logic dp_e, input logic done_e, input logic blank_tick);
    logic [3:0] ea;
    logic [1:0] nd;
    ea = 4'b1111 ^ (4'b0001 << d);
    nd = d + 2'd1;
    checks++; if (bus.anode !== ea) begin errors++; $display("FAIL lit_anode d=%0d got %b exp %b", d, bus.anode, ea); end
    checks++; if (bus.seg !== seg_e) begin errors++; $display("FAIL lit_seg d=%0d got %h exp %h", d, bus.seg, seg_e); end
    checks++; if (bus.dp !== dp_e) begin errors++; $display("FAIL lit_dp d=%0d got %b exp %b", d, bus.dp, dp_e); end
    checks++; if (bus.digit_idx !== d) begin errors++; $display("FAIL lit_idx got %0d exp %0d", bus.digit_idx, d); end
    repeat (12) @(negedge clock_in);
    checks++; if (bus.anode !== ea || bus.frame_done !== 1'b0) begin errors++; $display("FAIL dwell d=%0d anode %b done %b exp %b 0", d, bus.anode, bus.frame_done, ea); end
    bus.tick = 1'b1;
    @(negedge clock_in);
    bus.tick = blank_tick;
    checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL blank0_anode d=%0d got %b exp 1111", d, bus.anode); end
    checks++; if (bus.frame_done !== done_e) begin errors++; $display("FAIL frame_done d=%0d got %b exp %b", d, bus.frame_done, done_e); end
    checks++; if (bus.digit_idx !== nd) begin errors++; $display("FAIL next_idx got %0d exp %0d", bus.digit_idx, nd); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_in);
      checks++; if (bus.anode !== 4'b1111 || bus.frame_done !== 1'b0) begin errors++; $display("FAIL blank%0d d=%0d anode %b done %b exp 1111 0", i + 1, d, bus.anode, bus.frame_done); end
    end
    @(negedge clock_in);
    bus.tick = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.tick = 1'b0;
    bus.enable = 1'b0;
    bus.digits_in = 16'h0000;
    bus.dots_in = 4'b0000;
    @(negedge clock_in);
    checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL rst_anode got %b exp 1111", bus.anode); end
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h exp 7f", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL rst_dp got %b exp 1", bus.dp); end
    checks++; if (bus.digit_idx !== 2'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", bus.digit_idx); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.frame_done); end
  endtask
  task automatic test_startup;
    bus.digits_in = 16'h1234;
    bus.dots_in = 4'b0000;
    bus.enable = 1'b1;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock_in);
      checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL startup_blank edge %0d got %b exp 1111", i, bus.anode); end
    end
    @(negedge clock_in);
    checks++; if (bus.anode !== 4'b1110) begin errors++; $display("FAIL startup_anode got %b exp 1110", bus.anode); end
    checks++; if (bus.seg !== 7'h19) begin errors++; $display("FAIL startup_seg got %h exp 19", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL startup_dp got %b exp 1", bus.dp); end
  endtask
  task automatic test_full_frame;
    run_digit(2'd0, 7'h19, 1'b1, 1'b0, 1'b0);
    run_digit(2'd1, 7'h30, 1'b1, 1'b0, 1'b0);
    run_digit(2'd2, 7'h24, 1'b1, 1'b0, 1'b0);
    run_digit(2'd3, 7'h79, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_midframe_change;
    run_digit(2'd0, 7'h19, 1'b1, 1'b0, 1'b0);
    bus.digits_in = 16'hFFFF;
    run_digit(2'd1, 7'h30, 1'b1, 1'b0, 1'b0);
    run_digit(2'd2, 7'h24, 1'b1, 1'b0, 1'b0);
    run_digit(2'd3, 7'h79, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) run_digit(2'(i), 7'h0E, 1'b1, i == 3, 1'b0);
  endtask
  task automatic test_tick_in_blank;
    run_digit(2'd0, 7'h0E, 1'b1, 1'b0, 1'b1);
    run_digit(2'd1, 7'h0E, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_enable_drop;
    bus.digits_in = 16'hABCD;
    bus.enable = 1'b0;
    @(negedge clock_in);
    checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL dis_anode got %b exp 1111", bus.anode); end
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL dis_seg got %h exp 7f", bus.seg); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL dis_done got %b exp 0", bus.frame_done); end
    checks++; if (bus.digit_idx !== 2'd0) begin errors++; $display("FAIL dis_idx got %0d exp 0", bus.digit_idx); end
    bus.tick = 1'b1;
    @(negedge clock_in);
    bus.tick = 1'b0;
    checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL idle_tick_anode got %b exp 1111", bus.anode); end
    bus.enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock_in);
      checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL reen_blank edge %0d got %b exp 1111", i, bus.anode); end
    end
    @(negedge clock_in);
    run_digit(2'd0, 7'h21, 1'b1, 1'b0, 1'b0);
    run_digit(2'd1, 7'h46, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_async_reset;
    repeat (3) @(negedge clock_in);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL async_anode got %b exp 1111", bus.anode); end
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL async_seg got %h exp 7f", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL async_dp got %b exp 1", bus.dp); end
    checks++; if (bus.digit_idx !== 2'd0) begin errors++; $display("FAIL async_idx got %0d exp 0", bus.digit_idx); end
    bus.digits_in = 16'h1234;
    bus.dots_in = 4'b0001;
    @(negedge clock_in);
    reset = 1'b0;
    repeat (4) @(negedge clock_in);
    checks++; if (bus.anode !== 4'b1111) begin errors++; $display("FAIL restart_blank got %b exp 1111", bus.anode); end
    @(negedge clock_in);
    run_digit(2'd0, 7'h19, 1'b0, 1'b0, 1'b0);
    run_digit(2'd1, 7'h30, 1'b1, 1'b0, 1'b0);
    run_digit(2'd2, 7'h24, 1'b1, 1'b0, 1'b0);
    run_digit(2'd3, 7'h79, 1'b1, 1'b1, 1'b0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_startup;
    test_full_frame;
    test_midframe_change;
    test_tick_in_blank;
    test_enable_drop;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
